datapath_pipe: RTL and testbench

//  Parametrised two-stage successor of the 16-bit single-cycle datapath: a register file,
//  a function unit, the MB (constant) and MD (memory data) muxes, and V/C/N/Z flags.

---
 rtl/dp_pkg.sv | 46 ++++
 rtl/funcunit_p.sv | 59 +++++
 rtl/datapath_pipe.sv | 146 ++++++++++++++
 tb/tb_datapath_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the pipelined datapath: function-select codes,
// control-word field positions and the V/C/N/Z flag bundle.
package dp_pkg;

   typedef enum logic [3:0] {
      FS_TSA   = 4'h0,
      FS_INC   = 4'h1,
      FS_ADD   = 4'h2,
      FS_ADDC  = 4'h3,
      FS_ADDNB = 4'h4,
      FS_SUB   = 4'h5,
      FS_DEC   = 4'h6,
      FS_TSA2  = 4'h7,
      FS_AND   = 4'h8,
      FS_OR    = 4'h9,
      FS_XOR   = 4'hA,
      FS_NOTA  = 4'hB,
      FS_TSB   = 4'hC,
      FS_SHR   = 4'hD,
      FS_SHL   = 4'hE,
      FS_ZERO  = 4'hF
   } fs_e;

   typedef struct packed {
      logic v;
      logic c;
      logic n;
      logic z;
   } flags_t;

   // Control word is {DA, AA, BA, MB, FS[3:0], MD, RW}, MSB first
   localparam int unsigned CW_RW = 0;
   localparam int unsigned CW_MD = 1;
   localparam int unsigned CW_FS = 2;
   localparam int unsigned CW_MB = 6;
   localparam int unsigned CW_BA = 7;

   function automatic int unsigned cw_aa_lsb(input int unsigned aw);
      return 7 + aw;
   endfunction

   function automatic int unsigned cw_da_lsb(input int unsigned aw);
      return 7 + 2 * aw;
   endfunction

endpackage

// File: rtl/funcunit_p.sv
// Combinational function unit: decodes FS, produces result F and V/C/N/Z.
module funcunit_p
   import dp_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   fs,
   output logic [W-1:0] f,
   output logic         v,
   output logic         c,
   output logic         n,
   output logic         z
);

   logic [W-1:0] bop;
   logic         cin;
   logic [W:0]   sum;

   // FS 0-7 share one adder; only the B-side operand and carry-in differ
   always_comb begin
      bop = '0;
      cin = 1'b0;
      case (fs_e'(fs))
         FS_INC:   cin = 1'b1;
         FS_ADD:   bop = b;
         FS_ADDC:  begin bop = b;  cin = 1'b1; end
         FS_ADDNB: bop = ~b;
         FS_SUB:   begin bop = ~b; cin = 1'b1; end
         FS_DEC:   bop = '1;
         default:  ;
      endcase
      sum = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, cin};
   end

   always_comb begin
      f = sum[W-1:0];
      c = sum[W];
      v = (a[W-1] == bop[W-1]) && (sum[W-1] != a[W-1]);
      if (fs[3]) begin
         c = 1'b0;
         v = 1'b0;
         case (fs_e'(fs))
            FS_AND:  f = a & b;
            FS_OR:   f = a | b;
            FS_XOR:  f = a ^ b;
            FS_NOTA: f = ~a;
            FS_TSB:  f = b;
            FS_SHR:  begin f = {1'b0, b[W-1:1]}; c = b[0]; end
            FS_SHL:  begin f = {b[W-2:0], 1'b0}; c = b[W-1]; end
            default: f = '0;
         endcase
      end
      n = f[W-1];
      z = (f == '0);
   end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath: OF reads the register file, EX computes and writes back.
// Control words arrive on a valid/ready handshake; loads wait for DIN_VALID.
module datapath_pipe
   import dp_pkg::*;
#(
   parameter  int unsigned W       = 16,
   parameter  int unsigned NREG    = 8,
   parameter  int unsigned FORWARD = 1,
   localparam int unsigned AW      = $clog2(NREG),
   localparam int unsigned CWW     = 3 * AW + 7
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic [CWW-1:0] CTRWRD,
   input  logic           CW_VALID,
   output logic           CW_READY,
   input  logic [W-1:0]   Cin,
   input  logic [W-1:0]   Din,
   input  logic           DIN_VALID,
   output logic           MEM_RD,
   output logic [W-1:0]   Adrout,
   output logic [W-1:0]   Dout,
   output logic           V,
   output logic           C,
   output logic           N,
   output logic           Z
);

   localparam int unsigned AA_LSB = cw_aa_lsb(AW);
   localparam int unsigned DA_LSB = cw_da_lsb(AW);

   logic [W-1:0]  regs_q [NREG];
   logic [W-1:0]  regs_d [NREG];
   logic          ex_valid_q, ex_valid_d;
   logic [W-1:0]  ex_a_q, ex_a_d;
   logic [W-1:0]  ex_b_q, ex_b_d;
   logic [AW-1:0] ex_da_q, ex_da_d;
   logic [3:0]    ex_fs_q, ex_fs_d;
   logic          ex_md_q, ex_md_d;
   logic          ex_rw_q, ex_rw_d;
   flags_t        flags_q, flags_d;

   logic [AW-1:0] of_da, of_aa, of_ba;
   logic [3:0]    of_fs;
   logic          of_mb, of_md, of_rw;
   logic [W-1:0]  fu_f, bus_d, op_a, op_b;
   logic          fu_v, fu_c, fu_n, fu_z;
   logic          retire, load_stall, raw_a, raw_b, accept;

   assign of_da = CTRWRD[DA_LSB +: AW];
   assign of_aa = CTRWRD[AA_LSB +: AW];
   assign of_ba = CTRWRD[CW_BA +: AW];
   assign of_mb = CTRWRD[CW_MB];
   assign of_fs = CTRWRD[CW_FS +: 4];
   assign of_md = CTRWRD[CW_MD];
   assign of_rw = CTRWRD[CW_RW];

   funcunit_p #(.W(W)) u_fu (
      .a  (ex_a_q),
      .b  (ex_b_q),
      .fs (ex_fs_q),
      .f  (fu_f),
      .v  (fu_v),
      .c  (fu_c),
      .n  (fu_n),
      .z  (fu_z)
   );

   assign bus_d      = ex_md_q ? Din : fu_f;
   assign retire     = ex_valid_q && (!ex_md_q || DIN_VALID);
   assign load_stall = ex_valid_q && ex_md_q && !DIN_VALID;
   assign raw_a      = ex_valid_q && ex_rw_q && (of_aa == ex_da_q);
   assign raw_b      = ex_valid_q && ex_rw_q && !of_mb && (of_ba == ex_da_q);

   // Without bypass, a hazard holds OF for the cycle the write-back lands
   assign CW_READY = !load_stall && ((FORWARD != 0) || !(raw_a || raw_b));
   assign accept   = CW_VALID && CW_READY;

   always_comb begin
      op_a = regs_q[of_aa];
      op_b = regs_q[of_ba];
      if (FORWARD != 0 && retire && raw_a) op_a = bus_d;
      if (FORWARD != 0 && retire && raw_b) op_b = bus_d;
      if (of_mb) op_b = Cin;
   end

   always_comb begin
      regs_d     = regs_q;
      flags_d    = flags_q;
      ex_valid_d = ex_valid_q;
      ex_a_d     = ex_a_q;
      ex_b_d     = ex_b_q;
      ex_da_d    = ex_da_q;
      ex_fs_d    = ex_fs_q;
      ex_md_d    = ex_md_q;
      ex_rw_d    = ex_rw_q;
      if (retire) begin
         flags_d = '{v: fu_v, c: fu_c, n: fu_n, z: fu_z};
         if (ex_rw_q) regs_d[ex_da_q] = bus_d;
      end
      if (accept) begin
         ex_valid_d = 1'b1;
         ex_a_d     = op_a;
         ex_b_d     = op_b;
         ex_da_d    = of_da;
         ex_fs_d    = of_fs;
         ex_md_d    = of_md;
         ex_rw_d    = of_rw;
      end else if (retire) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         regs_q     <= '{default: '0};
         flags_q    <= '0;
         ex_valid_q <= 1'b0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         ex_da_q    <= '0;
         ex_fs_q    <= '0;
         ex_md_q    <= 1'b0;
         ex_rw_q    <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         flags_q    <= flags_d;
         ex_valid_q <= ex_valid_d;
         ex_a_q     <= ex_a_d;
         ex_b_q     <= ex_b_d;
         ex_da_q    <= ex_da_d;
         ex_fs_q    <= ex_fs_d;
         ex_md_q    <= ex_md_d;
         ex_rw_q    <= ex_rw_d;
      end
   end

   assign MEM_RD = ex_valid_q && ex_md_q;
   assign Adrout = ex_a_q;
   assign Dout   = ex_b_q;
   assign V      = flags_q.v;
   assign C      = flags_q.c;
   assign N      = flags_q.n;
   assign Z      = flags_q.z;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: instance 0 bypasses, instance 1 interlocks,
// instance 2 is the wide W=32 / NREG=16 build.
module tb_datapath_pipe;

   logic        clk;
   logic        rst_n;
   logic [18:0] cw_s   [3];
   logic        cv     [3];
   logic [31:0] cin_s  [3];
   logic [31:0] din_s  [3];
   logic        dv     [3];
   logic        rdy    [3];
   logic        mrd    [3];
   logic        v_o    [3];
   logic        c_o    [3];
   logic        n_o    [3];
   logic        z_o    [3];
   logic [15:0] adr0, adr1, dout0, dout1;
   logic [31:0] adr2, dout2;
   logic [31:0] adr_o  [3];
   logic [31:0] dout_o [3];

   int n_checks = 0;
   int n_pass   = 0;

   always_comb begin
      adr_o[0]  = {16'h0, adr0};
      adr_o[1]  = {16'h0, adr1};
      adr_o[2]  = adr2;
      dout_o[0] = {16'h0, dout0};
      dout_o[1] = {16'h0, dout1};
      dout_o[2] = dout2;
   end

   datapath_pipe #(.W(16), .NREG(8), .FORWARD(1)) u_fwd (
      .CLK(clk), .RESET(rst_n), .CTRWRD(cw_s[0][15:0]), .CW_VALID(cv[0]),
      .CW_READY(rdy[0]), .Cin(cin_s[0][15:0]), .Din(din_s[0][15:0]),
      .DIN_VALID(dv[0]), .MEM_RD(mrd[0]), .Adrout(adr0), .Dout(dout0),
      .V(v_o[0]), .C(c_o[0]), .N(n_o[0]), .Z(z_o[0])
   );

   datapath_pipe #(.W(16), .NREG(8), .FORWARD(0)) u_ilk (
      .CLK(clk), .RESET(rst_n), .CTRWRD(cw_s[1][15:0]), .CW_VALID(cv[1]),
      .CW_READY(rdy[1]), .Cin(cin_s[1][15:0]), .Din(din_s[1][15:0]),
      .DIN_VALID(dv[1]), .MEM_RD(mrd[1]), .Adrout(adr1), .Dout(dout1),
      .V(v_o[1]), .C(c_o[1]), .N(n_o[1]), .Z(z_o[1])
   );

   datapath_pipe #(.W(32), .NREG(16), .FORWARD(1)) u_wide (
      .CLK(clk), .RESET(rst_n), .CTRWRD(cw_s[2]), .CW_VALID(cv[2]),
      .CW_READY(rdy[2]), .Cin(cin_s[2]), .Din(din_s[2]),
      .DIN_VALID(dv[2]), .MEM_RD(mrd[2]), .Adrout(adr2), .Dout(dout2),
      .V(v_o[2]), .C(c_o[2]), .N(n_o[2]), .Z(z_o[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [18:0] cw(input int aw, input int da, input int aa, input int ba,
                                      input int mb, input int fs, input int md, input int rw);
      int t;
      t = (da << (7 + 2 * aw)) | (aa << (7 + aw)) | (ba << 7) | (mb << 6) |
          (fs << 2) | (md << 1) | rw;
      return t[18:0];
   endfunction

   function automatic logic [31:0] flg(input int k);
      return {28'h0, v_o[k], c_o[k], n_o[k], z_o[k]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int k, input logic [18:0] w, input logic [31:0] c, output int stalls);
      cw_s[k]  = w;
      cin_s[k] = c;
      cv[k]    = 1'b1;
      stalls   = 0;
      forever begin
         @(negedge clk);
         if (rdy[k]) break;
         stalls++;
         if (stalls > 20) begin
            check("send_timeout", {31'h0, rdy[k]}, 32'h1);
            break;
         end
      end
      tick();
      cv[k] = 1'b0;
   endtask

   task automatic readreg(input int k, input int aw, input int r, output logic [31:0] val);
      int s;
      send(k, cw(aw, 0, r, 0, 0, 0, 0, 0), 32'h0, s);
      @(negedge clk);
      val = adr_o[k];
      tick();
   endtask

   task automatic op_flags(input int k, input logic [18:0] w, input logic [31:0] c,
                           input logic [31:0] exp, input string tag);
      int s;
      send(k, w, c, s);
      tick();
      @(negedge clk);
      check(tag, flg(k), exp);
      tick();
   endtask

   task automatic run_alu(input int k, input int exp_stall);
      int s1, s2;
      logic [31:0] val;
      send(k, cw(3, 1, 0, 0, 1, 12, 0, 1), 32'd5, s1);
      send(k, cw(3, 2, 0, 0, 1, 12, 0, 1), 32'd3, s1);
      tick();
      send(k, cw(3, 3, 1, 2, 0, 2, 0, 1), 32'h0, s1);
      send(k, cw(3, 4, 3, 2, 0, 5, 0, 1), 32'h0, s2);
      check($sformatf("alu%0d_stall1", k), s1, 0);
      check($sformatf("alu%0d_stall2", k), s2, exp_stall);
      tick();
      @(negedge clk);
      check($sformatf("alu%0d_flags", k), flg(k), 32'h4);
      tick();
      readreg(k, 3, 3, val);
      check($sformatf("alu%0d_r3", k), val, 32'd8);
      readreg(k, 3, 4, val);
      check($sformatf("alu%0d_r4", k), val, 32'd5);
   endtask

   initial begin
      int s, rdy_lo, mrd_hi;
      logic [31:0] val;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cw_s[k] = '0; cv[k] = 1'b0; cin_s[k] = '0; din_s[k] = '0; dv[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'h0, rdy[0]}, 32'h1);
      check("rst_memrd", {31'h0, mrd[0]}, 32'h0);
      check("rst_flags", flg(0), 32'h0);
      check("rst_adr", adr_o[0], 32'h0);
      check("rst_dout", dout_o[2], 32'h0);
      tick();

      // Reset while a load waits for memory data
      send(0, cw(3, 1, 0, 0, 1, 12, 0, 1), 32'h8000, s);
      send(0, cw(3, 1, 0, 0, 1, 12, 1, 1), 32'h1234, s);
      @(negedge clk);
      check("t1_pre_memrd", {31'h0, mrd[0]}, 32'h1);
      check("t1_pre_ready", {31'h0, rdy[0]}, 32'h0);
      check("t1_pre_flags", flg(0), 32'h2);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("t1_ready", {31'h0, rdy[0]}, 32'h1);
      check("t1_memrd", {31'h0, mrd[0]}, 32'h0);
      check("t1_flags", flg(0), 32'h0);
      check("t1_adr", adr_o[0], 32'h0);
      tick();
      din_s[0] = 32'hBEEF;
      dv[0]    = 1'b1;
      readreg(0, 3, 1, val);
      check("t1_r1", val, 32'h0);

      run_alu(0, 0);
      run_alu(1, 1);

      // Load stalled three cycles; F (0x8001) differs from Din (0x8000)
      din_s[0] = 32'h1234;
      dv[0]    = 1'b0;
      send(0, cw(3, 2, 0, 0, 1, 12, 1, 1), 32'h8001, s);
      rdy_lo = 0;
      mrd_hi = 0;
      for (int i = 0; i < 6; i++) begin
         dv[0] = (i == 3);
         if (i == 3) din_s[0] = 32'h8000;
         @(negedge clk);
         if (!rdy[0]) rdy_lo++;
         if (mrd[0]) mrd_hi++;
         if (i == 2) check("t4_dout_hold", dout_o[0], 32'h8001);
         tick();
      end
      dv[0] = 1'b1;
      check("t4_ready_low", rdy_lo, 3);
      check("t4_memrd_high", mrd_hi, 4);
      @(negedge clk);
      check("t4_flags", flg(0), 32'h2);
      tick();
      readreg(0, 3, 2, val);
      check("t4_r2", val, 32'h8000);

      // Flag corner cases
      send(0, cw(3, 5, 0, 0, 1, 12, 0, 1), 32'h7FFF, s);
      send(0, cw(3, 6, 0, 0, 1, 12, 0, 1), 32'h0001, s);
      op_flags(0, cw(3, 7, 5, 6, 0, 2, 0, 0), 32'h0, 32'hA, "t5_ovf");
      op_flags(0, cw(3, 7, 5, 5, 0, 5, 0, 0), 32'h0, 32'h5, "t5_sub_eq");
      op_flags(0, cw(3, 0, 0, 0, 0, 6, 0, 0), 32'h0, 32'h2, "t5_dec0");
      op_flags(0, cw(3, 0, 0, 0, 1, 13, 0, 0), 32'h3, 32'h4, "t5_shr");
      op_flags(0, cw(3, 7, 0, 0, 1, 14, 0, 1), 32'h8001, 32'h4, "t5_shl");
      readreg(0, 3, 7, val);
      check("t5_r7", val, 32'h2);

      // Wide build
      send(2, cw(4, 15, 0, 0, 1, 12, 0, 1), 32'hDEAD_BEEF, s);
      tick();
      readreg(2, 4, 15, val);
      check("t6_r15_pre", val, 32'hDEAD_BEEF);
      op_flags(2, cw(4, 15, 0, 0, 1, 3, 0, 1), 32'hFFFF_FFFF, 32'h5, "t6_flags");
      readreg(2, 4, 15, val);
      check("t6_r15", val, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
